// File: rtl/trivium_pkg.sv
// trivium_pkg: shared sizes and serializer state encoding for the key/IV load path
package trivium_pkg;
   localparam int KEY_SZ_DFLT = 80;
   localparam int IV_SZ_DFLT  = 80;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/key_iv_serializer.sv
// key_iv_serializer: streams {key, iv} LSB first (IV first) into the cipher's serial load register
module key_iv_serializer
   import trivium_pkg::*;
#(
   parameter int KEY_SZ = KEY_SZ_DFLT,
   parameter int IV_SZ  = IV_SZ_DFLT
) (
   input  logic              clk_i,
   input  logic              n_rst_i,
   input  logic              ce_i,
   input  logic [KEY_SZ-1:0] key_i,
   input  logic [IV_SZ-1:0]  iv_i,
   input  logic              load_i,
   output logic              ready_o,
   input  logic              abort_i,
   output logic              ser_dat_o,
   output logic              ser_ce_o,
   output logic              busy_o,
   output logic              done_o
);
   localparam int TOT_SZ = KEY_SZ + IV_SZ;
   localparam int CNT_W  = $clog2(TOT_SZ + 1);

   state_t              state_q, state_d;
   logic [TOT_SZ-1:0]   sreg_q, sreg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last;

   assign last = cnt_q == CNT_W'(TOT_SZ - 1);

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (load_i) begin
            sreg_d  = {key_i, iv_i};
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: if (abort_i) begin
            sreg_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
         end else if (ce_i) begin
            sreg_d  = sreg_q >> 1;
            cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
            state_d = last ? DONE : SHIFT;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // the receiver must never see a strobe outside SHIFT or during an abort
   assign ready_o   = state_q == IDLE;
   assign busy_o    = (state_q == SHIFT) || (state_q == DONE);
   assign done_o    = state_q == DONE;
   assign ser_dat_o = (state_q == SHIFT) && sreg_q[0];
   assign ser_ce_o  = (state_q == SHIFT) && ce_i && !abort_i;
endmodule

// File: tb/tb_key_iv_serializer.sv
// tb_key_iv_serializer: randomized directed checks of the serializer against a loopback receiver model
module tb_key_iv_serializer;
   logic        clk_i = 1'b0;
   logic        n_rst_i = 1'b0;
   logic        ce_i = 1'b0;
   logic [79:0] key_i = '0;
   logic [79:0] iv_i = '0;
   logic        load_i = 1'b0;
   logic        abort_i = 1'b0;
   logic        ready_o, ser_dat_o, ser_ce_o, busy_o, done_o;
   logic [4:0]  st;
   int          n_cmp = 0;
   int          n_err = 0;

   key_iv_serializer dut (
      .clk_i(clk_i), .n_rst_i(n_rst_i), .ce_i(ce_i), .key_i(key_i), .iv_i(iv_i),
      .load_i(load_i), .ready_o(ready_o), .abort_i(abort_i), .ser_dat_o(ser_dat_o),
      .ser_ce_o(ser_ce_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;
   assign st = {ready_o, busy_o, done_o, ser_ce_o, ser_dat_o};

   task automatic chk_st(input string tag, input logic [4:0] exp);
      n_cmp++;
      assert (st === exp) else begin
         n_err++;
         $error("FAIL %s: {rdy,busy,done,ce,dat} got %b expected %b", tag, st, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [159:0] rev(input logic [159:0] x);
      logic [159:0] r;
      for (int i = 0; i < 160; i++) r[i] = x[159-i];
      return r;
   endfunction

   function automatic logic [79:0] rnd80();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[79:0];
   endfunction

   // Entered and left at posedge+1 of an IDLE cycle; bit n of {k,v} is due on strobe n.
   task automatic xfer(input logic [79:0] k, input logic [79:0] v, input int ce_pct,
                       input int abort_at, input int rst_at, input bit hold,
                       input logic [79:0] k2, input logic [79:0] v2, output logic [159:0] rx);
      logic [159:0] exp_w;
      int nstr, cyc;
      bit ab;
      exp_w = {k, v};
      rx = '0;
      nstr = 0;
      cyc = 0;
      key_i = k; iv_i = v; load_i = 1'b1;
      abort_i = 1'($urandom_range(1));
      ce_i = 1'($urandom_range(1));
      @(negedge clk_i);
      chk_st("idle_accept", 5'b10000);
      @(posedge clk_i); #1;
      load_i = hold;
      while (nstr < 160 && cyc < 2000) begin
         cyc++;
         if (hold && nstr == 80) begin key_i = k2; iv_i = v2; end
         ce_i = ($urandom_range(99) < ce_pct);
         ab = (nstr == abort_at);
         abort_i = ab;
         @(negedge clk_i);
         chk_st("shift", {3'b010, ce_i & ~ab, exp_w[nstr]});
         if (ce_i && !ab) begin
            rx = {rx[158:0], ser_dat_o};
            nstr++;
         end
         if (ab) begin
            @(posedge clk_i); #1;
            abort_i = 1'b0;
            repeat (3) begin
               @(negedge clk_i);
               chk_st("after_abort", 5'b10000);
               @(posedge clk_i); #1;
            end
            return;
         end
         if (nstr == rst_at) begin
            #2 n_rst_i = 1'b0;
            #1 chk_st("async_reset", 5'b10000);
            #1 n_rst_i = 1'b1;
            @(posedge clk_i); #1;
            chk_st("after_reset", 5'b10000);
            return;
         end
         @(posedge clk_i); #1;
      end
      chk_w("strobe_count", 160'(nstr), 160'd160);
      if (ce_pct == 100) chk_w("done_cycle", 160'(cyc + 1), 160'd161);
      ce_i = 1'b1;
      abort_i = 1'b1;
      @(negedge clk_i);
      chk_st("done", 5'b01100);
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      chk_st("idle_after_done", 5'b10000);
      chk_w("receiver", rx, rev(exp_w));
   endtask

   initial begin
      logic [159:0] rx;
      logic [79:0] ka, va, kb, vb;
      #1 chk_st("reset", 5'b10000);
      #22 n_rst_i = 1'b1;
      @(posedge clk_i); #1;
      chk_st("reset_release", 5'b10000);
      xfer(80'h0, 80'h1, 100, -1, -1, 1'b0, '0, '0, rx);
      chk_w("t1_rx", rx, 160'h1 << 159);
      xfer(80'h8000_0000_0000_0000_0000, 80'h0, 100, -1, -1, 1'b0, '0, '0, rx);
      chk_w("t2_rx", rx, 160'h1);
      repeat (3) xfer(rnd80(), rnd80(), 50, -1, -1, 1'b0, '0, '0, rx);
      xfer(rnd80(), rnd80(), 100, 37, -1, 1'b0, '0, '0, rx);
      ka = rnd80(); va = rnd80(); kb = rnd80(); vb = rnd80();
      xfer(ka, va, 70, -1, -1, 1'b1, kb, vb, rx);
      xfer(kb, vb, 100, -1, -1, 1'b0, '0, '0, rx);
      xfer(rnd80(), rnd80(), 100, -1, 100, 1'b0, '0, '0, rx);
      xfer(rnd80(), rnd80(), 100, -1, -1, 1'b0, '0, '0, rx);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
